// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// ram_arb_pkg : shared types and default sizes for the two-port RAM arbiter
// Revision    : 1.0
// ============================================================================
package ram_arb_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 6;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_sp.sv
`default_nettype none
// ============================================================================
// ram_sp   : single-port 2**AW x DW memory, write enable, registered read
// Revision : 1.0
// ============================================================================
module ram_sp
  import ram_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Array has no reset so it can map onto a block RAM; contents come from the init sweep.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register only moves on a read so the bus holds between transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : ram_sp
`default_nettype wire

// File: rtl/ram_arbiter_2p.sv
`default_nettype none
// ============================================================================
// ram_arbiter_2p : two requesters sharing one single-port RAM, round robin
// Revision       : 1.0
// ============================================================================
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            busy
);

  localparam logic [AW-1:0] c_cnt_last = '1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic          r_ptr;
  logic [1:0]    r_rvalid;

  logic [1:0]    w_gnt;
  logic          w_busy;
  logic          w_sel;
  logic          w_sel_we;
  logic          w_mem_we;
  logic          w_mem_re;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic [DW-1:0] w_mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (r_cnt == c_cnt_last) w_state_nxt = SERVE;
      SERVE:   w_state_nxt = SERVE;
      default: w_state_nxt = INIT;
    endcase
  end

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_busy = 1'b1;
    w_gnt  = 2'b00;
    if (r_state == SERVE) begin
      w_busy = 1'b0;
      case (req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_ptr ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign w_sel    = w_gnt[1];
  assign w_sel_we = w_sel ? we[1] : we[0];

  always_comb begin
    w_mem_we    = 1'b1;
    w_mem_re    = 1'b0;
    w_mem_addr  = r_cnt;
    w_mem_wdata = '0;
    if (r_state == SERVE) begin
      w_mem_we    = (|w_gnt) & w_sel_we;
      w_mem_re    = (|w_gnt) & ~w_sel_we;
      w_mem_addr  = w_sel ? addr[2*AW-1:AW] : addr[AW-1:0];
      w_mem_wdata = w_sel ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == INIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b1;
    end else if (|w_gnt) begin
      r_ptr <= w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 2'b00;
    end else begin
      r_rvalid <= w_gnt & ~we;
    end
  end

  ram_sp #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign gnt    = w_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = w_mem_rdata;
  assign busy   = w_busy;

endmodule : ram_arbiter_2p
`default_nettype wire

// File: tb/tb_ram_arbiter_2p.sv
`default_nettype none
// ============================================================================
// tb_ram_arbiter_2p : randomized self-checking bench with a behavioural model
// Revision          : 1.0
// ============================================================================
module tb_ram_arbiter_2p;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req;
  logic [1:0]      we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt;
  logic [1:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [DW-1:0] m_mem [DEPTH];
  int            m_init_left;
  int            m_ptr;
  logic [1:0]    m_rv;
  logic [DW-1:0] m_rd;

  // Per-cycle sampled and expected values
  logic [1:0]    s_gnt, s_rv, e_gnt, e_rv;
  logic [DW-1:0] s_rd, e_rd;
  logic          s_busy, e_busy;

  always #5 clk = ~clk;

  ram_arbiter_2p #(.DW(DW), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata),
    .busy   (busy)
  );

  function automatic logic [2*AW-1:0] pack_a(input int a1, input int a0);
    logic [AW-1:0] x1, x0;
    x1 = a1[AW-1:0];
    x0 = a0[AW-1:0];
    return {x1, x0};
  endfunction

  // Drive one cycle, sample outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic [1:0] rq, input logic [1:0] w,
                      input logic [2*AW-1:0] a, input logic [2*DW-1:0] d);
    int idx;
    req = rq; we = w; addr = a; wdata = d;
    @(negedge clk);
    s_gnt = gnt; s_rv = rvalid; s_rd = rdata; s_busy = busy;
    e_busy = (m_init_left > 0);
    e_rv   = m_rv;
    e_rd   = m_rd;
    e_gnt  = 2'b00;
    if (m_init_left == 0) begin
      if (rq == 2'b01)      e_gnt = 2'b01;
      else if (rq == 2'b10) e_gnt = 2'b10;
      else if (rq == 2'b11) e_gnt = 2'b01 << (1 - m_ptr);
    end
    @(posedge clk);
    m_rv = 2'b00;
    if (m_init_left > 0) begin
      m_mem[DEPTH - m_init_left] = '0;
      m_init_left--;
    end else if (e_gnt != 2'b00) begin
      idx   = (e_gnt == 2'b10) ? 1 : 0;
      m_ptr = idx;
      if (w[idx]) begin
        m_mem[a[idx*AW +: AW]] = d[idx*DW +: DW];
      end else begin
        m_rv = e_gnt;
        m_rd = m_mem[a[idx*AW +: AW]];
      end
    end
    #1;
  endtask

  task automatic do_reset(input logic [1:0] rq, input logic [1:0] w,
                          input logic [2*AW-1:0] a, input logic [2*DW-1:0] d);
    req = rq; we = w; addr = a; wdata = d;
    rst = 1'b1;
    @(posedge clk);
    m_init_left = DEPTH;
    m_rv        = 2'b00;
    m_rd        = '0;
    m_ptr       = 1;
    #1;
    rst = 1'b0;
    req = 2'b00;
  endtask

  task automatic test_reset();
    int nbusy = 0;
    do_reset(2'b00, 2'b00, '0, '0);
    for (int i = 0; i < 66; i++) begin
      step((i < 64) ? 2'($urandom_range(0, 3)) : 2'b00, 2'($urandom_range(0, 3)),
           2*AW'($urandom), 2*DW'($urandom));
      if (s_busy) nbusy++;
      n_checks++;
      if (s_gnt !== e_gnt || s_busy !== e_busy) begin
        n_fail++;
        $display("FAIL reset_init cyc%0d: gnt=%b busy=%b, want gnt=%b busy=%b", i, s_gnt, s_busy, e_gnt, e_busy);
      end
    end
    n_checks++;
    if (nbusy != 64) begin
      n_fail++;
      $display("FAIL busy_len: got %0d cycles, want 64", nbusy);
    end
  endtask

  task automatic test_readback_zero();
    int r;
    for (int i = 0; i <= DEPTH; i++) begin
      r = int'($urandom_range(0, 1));
      if (i < DEPTH) step(2'b01 << r, 2'b00, pack_a(i, i), '0);
      else           step(2'b00, 2'b00, '0, '0);
      n_checks++;
      if (s_gnt !== e_gnt || s_rv !== e_rv || s_rd !== e_rd ||
          (s_rv != 2'b00 && s_rd !== 8'h00)) begin
        n_fail++;
        $display("FAIL readback_zero i%0d: gnt=%b rv=%b rd=%h, want gnt=%b rv=%b rd=%h", i, s_gnt, s_rv, s_rd, e_gnt, e_rv, e_rd);
      end
    end
  endtask

  task automatic test_write_read();
    step(2'b01, 2'b01, pack_a(0, 5), {8'h00, 8'hA5});
    n_checks++;
    if (s_gnt !== 2'b01) begin n_fail++; $display("FAIL wr_gnt: got %b want 01", s_gnt); end
    step(2'b01, 2'b00, pack_a(0, 5), '0);
    n_checks++;
    if (s_gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt: got %b want 01", s_gnt); end
    step(2'b00, 2'b00, '0, '0);
    n_checks++;
    if (s_rv !== 2'b01 || s_rd !== 8'hA5 || e_rd !== 8'hA5) begin
      n_fail++;
      $display("FAIL wr_rd_data: rv=%b rd=%h, want rv=01 rd=a5", s_rv, s_rd);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] prev = 2'b00;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) step(2'b11, 2'b00, 2*AW'($urandom), '0);
      else       step(2'b00, 2'b00, '0, '0);
      n_checks++;
      if (s_gnt !== e_gnt || s_rv !== e_rv || s_rd !== e_rd ||
          (i > 0 && i < 5 && s_gnt === prev)) begin
        n_fail++;
        $display("FAIL round_robin i%0d: gnt=%b rv=%b rd=%h, want gnt=%b rv=%b rd=%h", i, s_gnt, s_rv, s_rd, e_gnt, e_rv, e_rd);
      end
      prev = s_gnt;
    end
  endtask

  task automatic test_req1_stream();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) step(2'b10, 2'b00, pack_a(i, 0), '0);
      else       step(2'b00, 2'b00, '0, '0);
      n_checks++;
      if ((i < 4 && s_gnt !== 2'b10) || (i > 0 && (s_rv !== 2'b10 || s_rd !== 8'h00)) ||
          s_gnt !== e_gnt || s_rv !== e_rv) begin
        n_fail++;
        $display("FAIL req1_stream i%0d: gnt=%b rv=%b rd=%h, want gnt=%b rv=%b rd=00", i, s_gnt, s_rv, s_rd, e_gnt, e_rv);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(2'b01, 2'b01, pack_a(0, 9), {8'h00, 8'h3C});
    step(2'b10, 2'b00, pack_a(9, 0), '0);
    n_checks++;
    if (s_gnt !== 2'b10) begin n_fail++; $display("FAIL b2b_gnt: got %b want 10", s_gnt); end
    step(2'b00, 2'b00, '0, '0);
    n_checks++;
    if (s_rv !== 2'b10 || s_rd !== 8'h3C) begin
      n_fail++;
      $display("FAIL b2b_data: rv=%b rd=%h, want rv=10 rd=3c", s_rv, s_rd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           pack_a(int'($urandom_range(0, 7)), int'($urandom_range(0, 7))), 2*DW'($urandom));
      n_checks++;
      if (s_gnt !== e_gnt || s_rv !== e_rv || s_rd !== e_rd || s_busy !== e_busy) begin
        n_fail++;
        $display("FAIL random i%0d: gnt=%b rv=%b rd=%h busy=%b, want gnt=%b rv=%b rd=%h busy=%b",
                 i, s_gnt, s_rv, s_rd, s_busy, e_gnt, e_rv, e_rd, e_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nbusy = 0;
    step(2'b01, 2'b01, pack_a(0, 63), {8'h00, 8'hFF});
    do_reset(2'b01, 2'b00, pack_a(0, 63), '0);
    for (int i = 0; i < 65; i++) begin
      step(2'b00, 2'b00, '0, '0);
      if (s_busy) nbusy++;
      n_checks++;
      if (s_rv !== 2'b00 || s_gnt !== 2'b00 || s_busy !== e_busy) begin
        n_fail++;
        $display("FAIL reset_mid i%0d: rv=%b gnt=%b busy=%b, want rv=00 gnt=00 busy=%b", i, s_rv, s_gnt, s_busy, e_busy);
      end
    end
    n_checks++;
    if (nbusy != 64) begin n_fail++; $display("FAIL reset_mid_len: got %0d cycles, want 64", nbusy); end
    step(2'b01, 2'b00, pack_a(0, 63), '0);
    step(2'b00, 2'b00, '0, '0);
    n_checks++;
    if (s_rv !== 2'b01 || s_rd !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_clear: rv=%b rd=%h, want rv=01 rd=00", s_rv, s_rd);
    end
  endtask

  initial begin
    rst = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    m_init_left = DEPTH; m_rv = 2'b00; m_rd = '0; m_ptr = 1;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hxx;
    test_reset();
    test_readback_zero();
    test_write_read();
    test_round_robin();
    test_req1_stream();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ram_arbiter_2p
`default_nettype wire
